pe_mac_seq: RTL
===============

Name: pe_mac_seq

Overview:
Sequencer that drives a single pe_mac processing element through a complete dot product. It accepts a job (base address, length), clears the accumulator, and fetches operand pairs from two synchronous-read operand buffers. It streams each pair into the MAC with a valid strobe, then returns the final accumulator value on a valid/ready result port. It sits between the job-issuing control logic and one PE, and is the building block for later multi-PE scheduling.

Parameters:
DATA_W, 8, operand width (matches pe_mac a/b)
ACC_W, 16, accumulator width (matches pe_mac acc)
ADDR_W, 6, operand buffer address width; DEPTH = 2**ADDR_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  job request; accepted only in IDLE
base  in  ADDR_W  first operand address
len  in  ADDR_W+1  number of products, 0..DEPTH
abort  in  1  cancel current job
busy  out  1  high from the cycle after acceptance until return to IDLE
mem_rd_en  out  1  read strobe to both buffers
mem_addr  out  ADDR_W  read address, shared by both buffers
mem_a_data  in  DATA_W  buffer A data, valid 1 cycle after mem_rd_en
mem_b_data  in  DATA_W  buffer B data, valid 1 cycle after mem_rd_en
mac_clr  out  1  accumulator clear, driven to the PE rst
mac_valid  out  1  PE valid
mac_a  out  DATA_W  PE operand a
mac_b  out  DATA_W  PE operand b
mac_acc  in  ACC_W  PE accumulator
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_data  out  ACC_W  dot-product result

Behaviour:
- Reset values: busy=0, mem_rd_en=0, mem_addr=0, mac_clr=0, mac_valid=0, mac_a=0, mac_b=0, res_valid=0, res_data=0. FSM is in IDLE.
- States are IDLE, CLEAR, RUN, WAIT, RESULT.
- IDLE: when start=1, latch base and len, clamping len>DEPTH to DEPTH.
  - If len==0, go to RESULT with res_data=0.
  - Otherwise go to CLEAR.
- CLEAR (1 cycle):
  - Assert mac_clr=1.
  - Assert mem_rd_en=1 with mem_addr=base.
  - Set idx=1, go to RUN.
- RUN (exactly len cycles):
  - mac_valid=1; mac_a and mac_b are mem_a_data and mem_b_data passed through combinationally.
  - While idx<len: mem_rd_en=1, mem_addr=(base+idx) mod DEPTH, idx++.
  - After the len-th valid cycle, go to WAIT.
- WAIT (1 cycle): mac_acc now includes the final product. Register res_data<=mac_acc and go to RESULT.
- RESULT:
  - res_valid=1 and res_data is held stable until res_valid&&res_ready.
  - On handshake, return to IDLE next cycle with res_valid=0.
- Latency: start accepted at edge 0, then CLEAR in cycle 1, RUN in cycles 2..len+1, WAIT in cycle len+2, res_valid first high in cycle len+3.
- Throughput: one product per cycle, no bubbles.
- mac_a and mac_b are 0 whenever mac_valid=0.
- start while busy: ignored, never queued.
- abort in CLEAR, RUN or WAIT:
  - Next cycle is IDLE; mac_valid, mem_rd_en and mac_clr go to 0.
  - No result is produced and res_data keeps its old value.
  - abort in RESULT or IDLE has no effect.
- Address wrap: base+idx wraps modulo DEPTH; len=DEPTH reads every entry exactly once.
- Arithmetic: the sequencer does no math. Overflow wraps modulo 2**ACC_W inside the PE and res_data reports the wrapped value.
- rst mid-job: all outputs return to reset values at the next edge. Any pending result is discarded.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package pe_pkg holds:
  - DATA_W and ACC_W defaults shared with pe_mac.
  - The state enum seq_state_t {IDLE, CLEAR, RUN, WAIT, RESULT}.
- One natural sub-module: pe_mac_seq_addr_gen, containing the idx counter, modulo address, last-read and last-valid flags, and the clamp.
- pe_mac is instantiated by the parent, not inside the sequencer.

Test Plan:
- Basic job: A=[2,4], B=[3,5], base=0, len=2 -> mac_valid high for 2 cycles, res_data=26, res_valid in cycle 5 after acceptance, mac_clr pulsed once.
- len=0 -> no mac_valid and no mem_rd_en; res_valid with res_data=0 in the cycle after acceptance.
- Overflow: A=B=[255,255], len=2 -> res_data=64514 (130050 mod 65536).
- Wrap and clamp: base=62, len=4 (ADDR_W=6) -> mem_addr sequence 62,63,0,1. Also len=100 -> treated as 64, exactly 64 valid cycles.
- Backpressure and ignored start:
  - Hold res_ready=0 for 5 cycles -> res_data constant, busy=1.
  - Pulse start during RESULT -> ignored.
  - After the handshake -> IDLE, and a new start is accepted.
- abort in the 2nd RUN cycle of a len=8 job -> next cycle IDLE, mac_valid=0, no res_valid. A following len=1 job with A=[7], B=[6] returns 42, proving the accumulator was cleared.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the pe_mac processing element and its job sequencer.
package pe_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int ADDR_W_DEF = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        WAIT   = 3'd3,
        RESULT = 3'd4
    } seq_state_t;

endpackage

// File: rtl/pe_mac_seq_addr_gen.sv
// Job address generator: latches base/clamped length and walks the operand
// index, flagging when reads run out and when the final product is valid.
module pe_mac_seq_addr_gen
    import pe_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W:0]   len_in,
    output logic              len_zero,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_more,
    output logic              last_valid
);

    localparam logic [ADDR_W:0]   DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ZERO_LEN  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W:0]   ONE_IDX   = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   len_clamped;

    // Clamp the requested length to the buffer depth before latching it.
    always_comb begin
        if (len_in > DEPTH_LEN) begin
            len_clamped = DEPTH_LEN;
        end else begin
            len_clamped = len_in;
        end
    end

    assign len_zero = (len_clamped == ZERO_LEN);

    // Next-state for the job registers and the running index.
    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        idx_d  = idx_q;
        if (load) begin
            base_d = base_in;
            len_d  = len_clamped;
            idx_d  = ZERO_LEN;
        end else if (step) begin
            idx_d  = idx_q + ONE_IDX;
        end else begin
            idx_d  = idx_q;
        end
    end

    // Job register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= ZERO_ADDR;
            len_q  <= ZERO_LEN;
            idx_q  <= ZERO_LEN;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
        end
    end

    // Truncation to ADDR_W bits gives the modulo-DEPTH wrap for free.
    assign addr       = base_q + idx_q[ADDR_W-1:0];
    assign rd_more    = (idx_q < len_q);
    assign last_valid = (idx_q == len_q);

endmodule

// File: rtl/pe_mac_seq.sv
// Dot-product sequencer: clears one pe_mac, streams len operand pairs from
// two synchronous-read buffers into it, and returns the accumulator.
module pe_mac_seq
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_a_data,
    input  logic [DATA_W-1:0] mem_b_data,
    output logic              mac_clr,
    output logic              mac_valid,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data
);

    localparam logic [ACC_W-1:0]  ZERO_ACC  = {ACC_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    seq_state_t        state_q, state_d;
    logic [ACC_W-1:0]  res_data_q, res_data_d;
    logic              accept;
    logic              step;
    logic              len_zero;
    logic [ADDR_W-1:0] gen_addr;
    logic              rd_more;
    logic              last_valid;

    assign accept = (state_q == IDLE) && start;
    assign step   = (state_q == CLEAR) || (state_q == RUN);

    pe_mac_seq_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .step       (step),
        .base_in    (base),
        .len_in     (len),
        .len_zero   (len_zero),
        .addr       (gen_addr),
        .rd_more    (rd_more),
        .last_valid (last_valid)
    );

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            res_data_q <= ZERO_ACC;
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
        end
    end

    // Next-state and result capture; abort only cancels the active phases.
    always_comb begin
        state_d    = state_q;
        res_data_d = res_data_q;
        case (state_q)
            IDLE: begin
                if (start && len_zero) begin
                    state_d    = RESULT;
                    res_data_d = ZERO_ACC;
                end else if (start) begin
                    state_d = CLEAR;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_valid) begin
                    state_d = WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            WAIT: begin
                // The PE has absorbed the last product by now.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d    = RESULT;
                    res_data_d = mac_acc;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESULT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; operands pass straight through from the buffers in RUN.
    always_comb begin
        busy      = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = ZERO_ADDR;
        mac_clr   = 1'b0;
        mac_valid = 1'b0;
        mac_a     = ZERO_DATA;
        mac_b     = ZERO_DATA;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            CLEAR: begin
                busy      = 1'b1;
                mac_clr   = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = gen_addr;
            end
            RUN: begin
                busy      = 1'b1;
                mac_valid = 1'b1;
                mac_a     = mem_a_data;
                mac_b     = mem_b_data;
                if (rd_more) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = gen_addr;
                end else begin
                    mem_rd_en = 1'b0;
                    mem_addr  = ZERO_ADDR;
                end
            end
            WAIT: begin
                busy = 1'b1;
            end
            RESULT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign res_data = res_data_q;

endmodule
